pc_counter: RTL and testbench
=============================

Name: pc_counter

Overview:
- Program counter register for the q2 discrete-transistor CPU.
- Built from one dff per bit plus a ripple-carry increment chain and a load/increment select per bit.
- It is the storage stage directly downstream of the dff cell: it consumes the dff q/nq outputs and drives the address bus.
- The fetch sequencer controls it through inc and load strobes; the jump path supplies din.

Parameters:
WIDTH, 12, counter width in bits (address bus width).
FANOUT_Q, 3, loads on each q output bit; passed to every dff instance.
FANOUT_NQ, 3, loads on each nq output bit; passed to every dff instance.

Ports:
clk  input  1  clock; state changes on the rising edge only.
clr  input  1  asynchronous, active-high reset; drives the clr pin of every dff.
inc  input  1  increment strobe, sampled at the rising clk edge.
load  input  1  parallel-load strobe, sampled at the rising clk edge.
din  input  WIDTH  load value.
q  output  WIDTH  current count.
nq  output  WIDTH  bitwise complement of q, taken directly from the dff nq pins.
co  output  1  carry out: 1 when inc=1, load=0 and q is all ones; combinational.

Behaviour:
- Reset:
  - clr=1 forces q=0, nq=all ones and co=0 immediately, with no clk edge needed.
  - While clr is held, clk, inc and load are ignored.
  - Release is asynchronous. The first edge that can change state is the first rising clk edge with clr=0.
  - If clr asserts mid-cycle or during an edge, clear wins. No partial load or increment survives.
- Per rising clk edge (clr=0), priority load > inc > hold:
  - load=1: q <= din. inc is ignored when load=1.
  - load=0, inc=1: q <= q+1, modulo 2^WIDTH.
  - load=0, inc=0: q holds.
- Latency: one clock. A new q is valid after the dff clk-to-q delay following the edge. There is no combinational path from din, inc or load to q.
- Wrap-around:
  - q=all ones with inc=1 gives q=0 at the next edge.
  - co=1 for the whole cycle before that edge and drops once q=0.
  - co never asserts during a load, including when din is all ones.
- Increment chain:
  - Bit i toggles when inc=1 and q[0..i-1] are all 1.
  - The carry ripples LSB to MSB. Worst-case settle is WIDTH half-adder delays and must complete within one clk low phase.
- Inputs:
  - inc, load and din must be stable around the rising edge (dff setup/hold).
  - Between edges they may glitch freely with no effect on q.
- nq is always the exact complement of q. There is no extra inverter stage.
- No set input: the counter cannot preset to nonzero other than through load.

Decomposition:
- Shared constants file holds PC_WIDTH (12) and the default fanout values, used by pc_counter and the fetch sequencer.
- One sub-module, pc_bit, is natural:
  - Contents: one dff, a half-adder slice (toggle = carry_in AND inc) and a 2:1 select between din[i] and the incremented bit.
  - Outputs: q[i], nq[i], carry_out.
- pc_counter instantiates WIDTH pc_bit slices in a chain and derives co from the final carry_out gated by NOT load.

Test Plan:
- Reset: clr=1 with arbitrary inc/load/din, then clr=0 with two idle clocks -> q=0x000, nq=0xFFF, co=0 throughout.
- Count: inc=1 for 5 edges from 0x000 -> q=0x001…0x005, one per edge; then inc=0 for 3 edges -> q stays 0x005.
- Load priority: din=0xA5C with load=1 and inc=1 on the same edge -> q=0xA5C (not 0xA5D); next edge with inc=1 only -> 0xA5D.
- Wrap: load 0xFFE, then inc for 2 edges -> q=0xFFF with co=1 during that cycle, then q=0x000 with co=0. Load din=0xFFF with inc=1 -> co=0.
- Async reset mid-operation: counting at 0x123, pulse clr between edges -> q=0x000 before the next edge; counting resumes 0x001 on the first edge after release.
- Hold-off: toggle din randomly between edges with load=0 and inc=0 for 8 edges -> q unchanged, nq==~q at every sample.

Source files
------------

// File: rtl/pc_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_counter_pkg
//  Description : Shared constants for the q2 program counter and the fetch
//                sequencer: address width and default dff output loading.
//  Revision    : 1.0  initial release
// ============================================================================
package pc_counter_pkg;

    // Address bus width of the q2 CPU.
    localparam int c_PC_WIDTH = 12;

    // Default number of loads hung on each dff q / nq pin.
    localparam int c_FANOUT_Q_DEFAULT  = 3;
    localparam int c_FANOUT_NQ_DEFAULT = 3;

endpackage : pc_counter_pkg
`default_nettype wire

// File: rtl/pc_bit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_bit
//  Description : One program-counter slice. It holds one dff with an
//                asynchronous clear, a half-adder toggle stage and a 2:1
//                load/increment select. Carry ripples in through i_carry
//                and out through o_carry toward the MSB.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_bit
    import pc_counter_pkg::*;
#(
    parameter int FANOUT_Q  = c_FANOUT_Q_DEFAULT,
    parameter int FANOUT_NQ = c_FANOUT_NQ_DEFAULT
) (
    input  logic clk,
    input  logic clr,
    input  logic i_inc,
    input  logic i_load,
    input  logic i_din,
    input  logic i_carry,
    output logic o_q,
    output logic o_nq,
    output logic o_carry
);

    logic r_q;
    logic w_toggle;
    logic w_inc_bit;
    logic w_d;

    // The fanout values size the dff output drive in the transistor netlist.
    // They have no logical effect, so the RTL only records them here. A dff
    // that drives no loads makes no sense, and that case builds nothing.
    if (FANOUT_Q < 1 || FANOUT_NQ < 1) begin : g_fanout_unloaded
    end

    // Half-adder slice: toggle when every lower bit is 1 and inc is asserted.
    always_comb begin
        w_toggle  = i_carry & i_inc;
        w_inc_bit = r_q ^ w_toggle;
        w_d       = i_load ? i_din : w_inc_bit;
        o_carry   = w_toggle & r_q;
    end

    // dff storage; clear acts immediately and overrides any clock edge.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_q <= 1'b0;
        end else begin
            r_q <= w_d;
        end
    end

    // nq is the complementary dff output pin, not a separate stage.
    assign o_q  = r_q;
    assign o_nq = ~r_q;

endmodule : pc_bit
`default_nettype wire

// File: rtl/pc_counter.sv
`default_nettype none
// ============================================================================
//  Module      : pc_counter
//  Description : q2 program counter. It chains WIDTH pc_bit slices into a
//                ripple-carry counter with parallel load. Priority is
//                load > inc > hold. co flags the all-ones wrap on an
//                increment cycle and is suppressed during loads.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_counter
    import pc_counter_pkg::*;
#(
    parameter int WIDTH     = c_PC_WIDTH,
    parameter int FANOUT_Q  = c_FANOUT_Q_DEFAULT,
    parameter int FANOUT_NQ = c_FANOUT_NQ_DEFAULT
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nq,
    output logic             co
);

    // w_carry[i] is high when bits 0..i-1 are all ones and inc is asserted.
    logic [WIDTH:0] w_carry;

    assign w_carry[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pc_bit #(
            .FANOUT_Q  (FANOUT_Q),
            .FANOUT_NQ (FANOUT_NQ)
        ) u_bit (
            .clk     (clk),
            .clr     (clr),
            .i_inc   (inc),
            .i_load  (load),
            .i_din   (din[i]),
            .i_carry (w_carry[i]),
            .o_q     (q[i]),
            .o_nq    (nq[i]),
            .o_carry (w_carry[i+1])
        );
    end

    // Carry out only on a real increment past all ones; a load never wraps.
    assign co = w_carry[WIDTH] & ~load;

endmodule : pc_counter
`default_nettype wire

// File: tb/tb_pc_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_counter
//  Description : Self-checking bench for pc_counter. Directed vectors push
//                hand-computed expected q/co into a scoreboard queue, and a
//                monitor pops and compares them at each falling clk edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_counter;

    localparam int c_W = 12;

    typedef struct {
        logic [c_W-1:0] q;
        logic           co;
        string          name;
    } exp_t;

    logic           clk;
    logic           clr;
    logic           inc;
    logic           load;
    logic [c_W-1:0] din;
    logic [c_W-1:0] q;
    logic [c_W-1:0] nq;
    logic           co;

    exp_t sb[$];
    int   checks;
    int   failures;
    bit   done;

    pc_counter #(
        .WIDTH     (c_W),
        .FANOUT_Q  (3),
        .FANOUT_NQ (3)
    ) dut (
        .clk  (clk),
        .clr  (clr),
        .inc  (inc),
        .load (load),
        .din  (din),
        .q    (q),
        .nq   (nq),
        .co   (co)
    );

    // 10-unit clock; rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [c_W-1:0] act,
                       input logic [c_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%03h expected 0x%03h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the DUT state is stable mid-cycle, so compare on the falling edge.
    exp_t m_e;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            m_e = sb.pop_front();
            chk({m_e.name, ".q"},  q,  m_e.q);
            chk({m_e.name, ".nq"}, nq, ~m_e.q);
            chk({m_e.name, ".co"}, {{(c_W-1){1'b0}}, co}, {{(c_W-1){1'b0}}, m_e.co});
        end
    end

    // One cycle: after the rising edge, q should equal exp_q. New inputs are
    // applied for the next edge, and co is the value expected with those inputs.
    task automatic cyc(input logic c, input logic i, input logic l,
                       input logic [c_W-1:0] d, input logic [c_W-1:0] exp_q,
                       input logic exp_co, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        clr  = c;
        inc  = i;
        load = l;
        din  = d;
        e.q = exp_q; e.co = exp_co; e.name = name;
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        checks   = 0;
        failures = 0;
        done     = 1'b0;
        clr  = 1'b1;
        inc  = 1'b1;
        load = 1'b1;
        din  = 12'h7AB;

        // Reset held with busy inputs, then released into two idle clocks.
        cyc(1, 1, 1, 12'h7AB, 12'h000, 0, "rst_hold0");
        cyc(1, 1, 1, 12'h3C1, 12'h000, 0, "rst_hold1");
        cyc(0, 0, 0, 12'h000, 12'h000, 0, "rst_rel0");
        cyc(0, 0, 0, 12'h000, 12'h000, 0, "rst_rel1");

        // Count five edges, then hold three.
        cyc(0, 1, 0, 12'h000, 12'h000, 0, "cnt0");
        cyc(0, 1, 0, 12'h000, 12'h001, 0, "cnt1");
        cyc(0, 1, 0, 12'h000, 12'h002, 0, "cnt2");
        cyc(0, 1, 0, 12'h000, 12'h003, 0, "cnt3");
        cyc(0, 1, 0, 12'h000, 12'h004, 0, "cnt4");
        cyc(0, 0, 0, 12'h000, 12'h005, 0, "hold0");
        cyc(0, 0, 0, 12'h000, 12'h005, 0, "hold1");
        cyc(0, 0, 0, 12'h000, 12'h005, 0, "hold2");

        // Load wins over inc on the same edge.
        cyc(0, 1, 1, 12'hA5C, 12'h005, 0, "ldpri_set");
        cyc(0, 1, 0, 12'h000, 12'hA5C, 0, "ldpri_ld");
        cyc(0, 0, 1, 12'hFFE, 12'hA5D, 0, "ldpri_inc");

        // Wrap through all ones; co only on the increment cycle.
        cyc(0, 1, 0, 12'h000, 12'hFFE, 0, "wrap_fe");
        cyc(0, 1, 0, 12'h000, 12'hFFF, 1, "wrap_ff_co");
        cyc(0, 1, 1, 12'hFFF, 12'h000, 0, "wrap_zero");
        cyc(0, 1, 1, 12'hFFF, 12'hFFF, 0, "ld_ff_noco");
        cyc(0, 0, 1, 12'h123, 12'hFFF, 0, "ld_ff_hold");

        // Async clear mid-cycle while counting.
        cyc(0, 1, 0, 12'h000, 12'h123, 0, "acl_123");
        cyc(0, 1, 0, 12'h000, 12'h124, 0, "acl_124");
        @(posedge clk);
        #1;
        clr = 1'b1;
        e.q = 12'h000; e.co = 1'b0; e.name = "acl_clear";
        sb.push_back(e);
        #2;
        clr = 1'b0;
        cyc(0, 0, 0, 12'h000, 12'h001, 0, "acl_resume");

        // din glitches between edges with load=0 and inc=0: q must not move.
        for (int k = 0; k < 8; k++) begin
            cyc(0, 0, 0, 12'($urandom), 12'h001, 0, "holdoff");
            #2;
            din = 12'($urandom);
        end

        // Drain the scoreboard.
        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends with a summary.
    initial begin
        #5000;
        if (!done) begin
            failures++;
            $display("FAIL watchdog: got timeout expected completion");
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

endmodule : tb_pc_counter
`default_nettype wire
